// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit common-anode 7-segment driver fed by a one-hot ring counter.
// Define HEX_DIGITS_EN to decode digit values A-F; otherwise they show blank segments.
module seg7_scan_driver #(
    parameter int BLANK_CYCLES = 4,
    parameter int ERR_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ring,
    input  logic [31:0] digits,
    input  logic [7:0]  dp,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [2:0]  digit_idx,
    output logic        err
);

    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int IW = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
    localparam logic [BW-1:0] BRELOAD = BW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IMAX    = IW'(ERR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW, FAULT} state_t;

    state_t        state, state_n;
    logic [7:0]    ring_q;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [IW-1:0] icnt, icnt_n;

    logic          change, valid, fault_hit;
    logic [3:0]    ones;
    logic [2:0]    idx;
    logic [3:0]    nib;

    logic [7:0]    an_n;
    logic [6:0]    seg_n;
    logic          dpn_n;
    logic [2:0]    idx_n;
    logic          err_n;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
`ifdef HEX_DIGITS_EN
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            4'hF: decode = 7'b0001110;
`endif
            default: decode = 7'h7F;
        endcase
    endfunction

    always_comb begin
        ones = '0;
        idx  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            ones = ones + {3'b000, ring_q[i]};
            if (ring_q[i]) idx = 3'(i);
        end
        valid     = (ones == 4'd1);
        change    = (ring != ring_q);
        fault_hit = !valid && (icnt == IMAX);
        nib       = digits[{idx, 2'b00} +: 4];
    end

    // Invalid counter saturates so FAULT is held until a valid ring_q appears.
    always_comb begin
        state_n = state;
        bcnt_n  = bcnt;
        if (valid)             icnt_n = '0;
        else if (icnt == IMAX) icnt_n = icnt;
        else                   icnt_n = icnt + 1'b1;

        case (state)
            IDLE: begin
                if (fault_hit) state_n = FAULT;
                else if (change) begin
                    state_n = BLANK;
                    bcnt_n  = BRELOAD;
                end
            end
            BLANK: begin
                if (fault_hit)               state_n = FAULT;
                else if (change || !valid)   bcnt_n  = BRELOAD;
                else if (bcnt == '0)         state_n = SHOW;
                else                         bcnt_n  = bcnt - 1'b1;
            end
            SHOW: begin
                if (fault_hit) state_n = FAULT;
                else if (change) begin
                    state_n = BLANK;
                    bcnt_n  = BRELOAD;
                end
            end
            FAULT: begin
                if (valid) begin
                    state_n = BLANK;
                    bcnt_n  = BRELOAD;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs follow the next state so they land on the same edge as the transition.
    always_comb begin
        an_n  = '1;
        seg_n = '1;
        dpn_n = 1'b1;
        idx_n = '0;
        if (state_n == SHOW) begin
            an_n  = ~ring_q;
            idx_n = idx;
            seg_n = decode(nib);
            dpn_n = ~dp[idx];
        end
        err_n = (state_n == FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ring_q    <= '0;
            bcnt      <= '0;
            icnt      <= '0;
            an        <= '1;
            seg       <= '1;
            dp_n      <= 1'b1;
            digit_idx <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            ring_q    <= ring;
            bcnt      <= bcnt_n;
            icnt      <= icnt_n;
            an        <= an_n;
            seg       <= seg_n;
            dp_n      <= dpn_n;
            digit_idx <= idx_n;
            err       <= err_n;
        end
    end

endmodule
